// File: rtl/food_spawner.sv
// food_spawner: on each rising edge of generate_food, draws LFSR candidates until it finds a grid cell the occupancy store reports free.
// Define FOOD_SCAN_FALLBACK_EN to raster-scan the grid once the random draws run out; otherwise exhaustion pulses FAIL.
module food_spawner #(
    parameter int          GRID_W    = 32,
    parameter int          GRID_H    = 24,
    parameter int          X_W       = 5,
    parameter int          Y_W       = 5,
    parameter int          MAX_TRIES = 64,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic           clk,
    input  logic           RST,
    input  logic           generate_food,
    output logic           OCC_REQ,
    output logic [X_W-1:0] OCC_X,
    output logic [Y_W-1:0] OCC_Y,
    input  logic           OCC_HIT,
    output logic [X_W-1:0] FOOD_X,
    output logic [Y_W-1:0] FOOD_Y,
    output logic           FOOD_VALID,
    output logic           BUSY,
    output logic           DONE,
    output logic           FAIL
);

    localparam int             TRY_W    = $clog2(MAX_TRIES + 1);
    localparam logic [X_W:0]   X_LIMIT  = (X_W + 1)'(GRID_W);
    localparam logic [Y_W:0]   Y_LIMIT  = (Y_W + 1)'(GRID_H);
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);
`ifdef FOOD_SCAN_FALLBACK_EN
    localparam logic [X_W-1:0] X_LAST   = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_LAST   = Y_W'(GRID_H - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        DRAW,
        QUERY,
        CHECK,
        FIN
`ifdef FOOD_SCAN_FALLBACK_EN
        , SCAN_Q
        , SCAN_C
`endif
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [15:0]      r_lfsr;
    logic             r_genPrev;
    logic [TRY_W-1:0] r_tries;
    logic [X_W-1:0]   r_candX;
    logic [Y_W-1:0]   r_candY;
    logic [X_W-1:0]   r_foodX;
    logic [Y_W-1:0]   r_foodY;
    logic             r_foodValid;
    logic             r_fail;

    logic [X_W-1:0]   w_drawX;
    logic [Y_W-1:0]   w_drawY;
    logic             w_drawOk;
    logic             w_request;
    logic             w_lastTry;
    logic             w_exhaust;
    logic             w_clrTry;
    logic             w_incTry;
    logic             w_loadCand;
    logic             w_loadFood;
    logic             w_failSet;
`ifdef FOOD_SCAN_FALLBACK_EN
    logic             w_scanStart;
    logic             w_scanAdv;
    logic             w_scanLast;
`endif

    assign w_drawX   = r_lfsr[X_W-1:0];
    assign w_drawY   = r_lfsr[X_W+Y_W-1:X_W];
    assign w_drawOk  = ({1'b0, w_drawX} < X_LIMIT) && ({1'b0, w_drawY} < Y_LIMIT);
    assign w_request = generate_food & ~r_genPrev;
    assign w_lastTry = (r_tries == TRY_LAST);
`ifdef FOOD_SCAN_FALLBACK_EN
    assign w_scanLast = (r_candX == X_LAST) && (r_candY == Y_LAST);
`endif

    // The lookup coordinates are the candidate register, which only changes on entry to a query state.
    assign OCC_X      = r_candX;
    assign OCC_Y      = r_candY;
    assign FOOD_X     = r_foodX;
    assign FOOD_Y     = r_foodY;
    assign FOOD_VALID = r_foodValid;
    assign FAIL       = r_fail;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_clrTry   = 1'b0;
        w_incTry   = 1'b0;
        w_loadCand = 1'b0;
        w_loadFood = 1'b0;
        w_failSet  = 1'b0;
        w_exhaust  = 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
        w_scanStart = 1'b0;
        w_scanAdv   = 1'b0;
`endif
        OCC_REQ    = 1'b0;
        BUSY       = (r_state != IDLE);
        DONE       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_request) begin
                    w_clrTry = 1'b1;
                    w_next   = DRAW;
                end
            end
            DRAW: begin
                if (w_drawOk) begin
                    w_loadCand = 1'b1;
                    w_next     = QUERY;
                end else begin
                    w_incTry  = 1'b1;
                    w_exhaust = w_lastTry;
                end
            end
            QUERY: begin
                OCC_REQ = 1'b1;
                w_next  = CHECK;
            end
            CHECK: begin
                if (!OCC_HIT) begin
                    w_loadFood = 1'b1;
                    w_next     = FIN;
                end else begin
                    w_incTry  = 1'b1;
                    w_exhaust = w_lastTry;
                    w_next    = DRAW;
                end
            end
`ifdef FOOD_SCAN_FALLBACK_EN
            SCAN_Q: begin
                OCC_REQ = 1'b1;
                w_next  = SCAN_C;
            end
            SCAN_C: begin
                if (!OCC_HIT) begin
                    w_loadFood = 1'b1;
                    w_next     = FIN;
                end else if (w_scanLast) begin
                    w_failSet = 1'b1;
                    w_next    = IDLE;
                end else begin
                    w_scanAdv = 1'b1;
                    w_next    = SCAN_Q;
                end
            end
`endif
            FIN: begin
                DONE   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
        if (w_exhaust) begin
`ifdef FOOD_SCAN_FALLBACK_EN
            w_scanStart = 1'b1;
            w_next      = SCAN_Q;
`else
            w_failSet   = 1'b1;
            w_next      = IDLE;
`endif
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_lfsr      <= LFSR_SEED;
            r_genPrev   <= 1'b0;
            r_tries     <= '0;
            r_candX     <= '0;
            r_candY     <= '0;
            r_foodX     <= '0;
            r_foodY     <= '0;
            r_foodValid <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_lfsr    <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
            r_genPrev <= generate_food;
            r_fail    <= w_failSet;
            if (w_clrTry) begin
                r_tries <= '0;
            end else if (w_incTry) begin
                r_tries <= r_tries + 1'b1;
            end
            if (w_loadCand) begin
                r_candX <= w_drawX;
                r_candY <= w_drawY;
`ifdef FOOD_SCAN_FALLBACK_EN
            end else if (w_scanStart) begin
                r_candX <= '0;
                r_candY <= '0;
            end else if (w_scanAdv) begin
                if (r_candX == X_LAST) begin
                    r_candX <= '0;
                    r_candY <= r_candY + 1'b1;
                end else begin
                    r_candX <= r_candX + 1'b1;
                end
`endif
            end
            if (w_loadFood) begin
                r_foodX     <= r_candX;
                r_foodY     <= r_candY;
                r_foodValid <= 1'b1;
            end
        end
    end

endmodule

// File: doc/food_spawner.md
Name: food_spawner

Overview:
- Responder to the game controller's `generate_food` request.
- On each request, picks a pseudo-random grid cell not occupied by the snake body and returns it as the new food position with a one-cycle `DONE` strobe.
- Queries the body/occupancy store through a one-cycle-latency lookup port.
- Sits between the game state machine and the snake body memory; feeds the renderer and collision logic.

Parameters:
- GRID_W, 32, grid columns (1..2^X_W)
- GRID_H, 24, grid rows (1..2^Y_W)
- X_W, 5, column coordinate width
- Y_W, 5, row coordinate width
- MAX_TRIES, 64, random draws allowed per request before fallback/fail
- LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
- clk  in  1  system clock, all logic on rising edge
- RST  in  1  reset, asynchronous, active-high
- generate_food  in  1  request level from state machine; rising edge starts a spawn
- OCC_REQ  out  1  occupancy lookup strobe
- OCC_X  out  X_W  lookup column
- OCC_Y  out  Y_W  lookup row
- OCC_HIT  in  1  cell occupied; valid exactly one cycle after OCC_REQ
- FOOD_X  out  X_W  current food column
- FOOD_Y  out  Y_W  current food row
- FOOD_VALID  out  1  food position is valid
- BUSY  out  1  spawn in progress
- DONE  out  1  one-cycle pulse: spawn finished, new FOOD_X/Y valid
- FAIL  out  1  one-cycle pulse: no free cell found; food unchanged

Behaviour:
- Reset values: all outputs 0; LFSR = LFSR_SEED; state IDLE; try counter 0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle regardless of state.
- Request detection:
  - Registered copy of `generate_food`; request = input high while registered copy low.
  - Edges while BUSY are ignored and not queued.
- States: IDLE, DRAW, QUERY, CHECK, SCAN_Q, SCAN_C, FIN.
- IDLE: on request go to DRAW; BUSY=1; try counter cleared.
- DRAW:
  - Candidate x = LFSR[X_W-1:0], y = LFSR[X_W+Y_W-1:X_W].
  - If x>=GRID_W or y>=GRID_H: try counter +1, stay in DRAW.
  - Otherwise latch candidate, go to QUERY.
- QUERY: OCC_REQ=1 for exactly this cycle, OCC_X/OCC_Y = candidate; go to CHECK.
- CHECK: sample OCC_HIT.
  - OCC_HIT=0: go to FIN.
  - OCC_HIT=1: try counter +1. If counter reaches MAX_TRIES go to fallback; else go to DRAW.
- Try counter saturation: rejected draws and occupied hits both count; counter never exceeds MAX_TRIES.
- FIN:
  - FOOD_X/Y = candidate; FOOD_VALID=1; DONE=1 for one cycle; BUSY=0; go to IDLE.
- Minimum latency: request edge seen in cycle N → DONE in cycle N+4.
- OCC_X/OCC_Y hold their last value when OCC_REQ=0.
- DONE and FAIL are never asserted together and never back-to-back for one request.
- RST mid-operation: immediate return to IDLE; FOOD_VALID cleared; no DONE/FAIL pulse emitted.
- Simultaneous request edge and FIN: edge ignored (BUSY still high that cycle).

Optional Feature:
- Macro: FOOD_SCAN_FALLBACK_EN.
- Defined:
  - On MAX_TRIES exhaustion, raster-scan from (0,0): x increments, wraps to 0 at GRID_W-1 with y+1.
  - SCAN_Q issues OCC_REQ; SCAN_C samples OCC_HIT.
  - First free cell goes to FIN.
  - If cell (GRID_W-1, GRID_H-1) is occupied: FAIL pulse, go to IDLE.
- Not defined:
  - MAX_TRIES exhaustion → FAIL pulse, BUSY=0, go to IDLE.
  - FOOD_X/Y/FOOD_VALID unchanged; SCAN states absent.

Test Plan:
- Reset, then no request → all outputs 0; OCC_REQ never asserted over 100 cycles.
- OCC_HIT tied 0; raise generate_food at cycle 10 → OCC_REQ once; DONE at cycle 14; FOOD_X<32, FOOD_Y<24; FOOD_VALID=1; BUSY low after DONE.
- Model returns OCC_HIT=1 for first 3 queries, then 0 → exactly 4 OCC_REQ pulses; DONE once; FOOD equals the 4th queried cell.
- OCC_HIT always 1:
  - without macro → FAIL after at most 64 tries; FOOD unchanged.
  - with macro → 768-cell scan, then FAIL.
  - with macro, only (7,3) free → DONE with FOOD=(7,3).
- Toggle generate_food twice while BUSY → only one DONE. Assert RST during CHECK → BUSY=0, FOOD_VALID=0, no DONE.
- 1000 requests with random hit model → every DONE cell had OCC_HIT=0 in its CHECK cycle; coordinates always in range.
